// File: rtl/life_ctrl_4x4.sv
// life_ctrl_4x4: sequencer for a 4x4 Game-of-Life cell array.
//   Loads a 16-bit seed cell by cell, then advances generations (scan window
//   followed by a one-cycle run pulse), single-step or free-running at a set
//   period. Counts generations and flags extinct / stable boards.
// Build option: define LIFE_CTRL_AUTOSTOP_EN to halt free-run once a
//   generation comes out extinct or stable.
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   load_req/pattern    load seed (bit 4*r+c = cell r,c)
//   step_req            advance one generation
//   run_en, gen_period  free-run enable and idle gap between generations
//   busy, gen_count     status: not idle, generations since last load
//   extinct, stable     result flags of the last generation
//   row/col/val/write_enb, scan, run   array control
//   alive               array state, same bit mapping as load_pattern
module life_ctrl_4x4 #(
    parameter int unsigned SCAN_CYCLES = 16,
    parameter int unsigned PERIOD_W    = 16,
    parameter int unsigned GEN_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_req,
    input  logic [15:0]         load_pattern,
    input  logic                step_req,
    input  logic                run_en,
    input  logic [PERIOD_W-1:0] gen_period,
    output logic                busy,
    output logic [GEN_W-1:0]    gen_count,
    output logic                extinct,
    output logic                stable,
    output logic [1:0]          row,
    output logic [1:0]          col,
    output logic                val,
    output logic                write_enb,
    output logic                scan,
    output logic                run,
    input  logic [15:0]         alive
);

    localparam int unsigned CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SCAN, S_STEP, S_CHECK, S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [15:0]         pattern_q, pattern_d;
    logic [15:0]         snap_q, snap_d;
    logic                pend_q, pend_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [GEN_W-1:0]    gen_q, gen_d;
    logic                extinct_q, extinct_d;
    logic                stable_q, stable_d;
    logic                busy_q, busy_d;
    logic [1:0]          row_q, row_d;
    logic [1:0]          col_q, col_d;
    logic                val_q, val_d;
    logic                we_q, we_d;
    logic                scan_q, scan_d;
    logic                run_q, run_d;
    logic                run_ok;
    logic                chk_ext, chk_stab;

    assign chk_ext  = (alive == 16'h0000);
    assign chk_stab = (alive == snap_q);

`ifdef LIFE_CTRL_AUTOSTOP_EN
    logic halt_q, halt_d;
    assign run_ok = run_en && !halt_q;
`else
    assign run_ok = run_en;
`endif

    // Next-state and next-output logic; outputs follow the next state.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pattern_d = pattern_q;
        snap_d    = snap_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        gen_d     = gen_q;
        extinct_d = extinct_q;
        stable_d  = stable_q;
        row_d     = row_q;
        col_d     = col_q;
        val_d     = val_q;
`ifdef LIFE_CTRL_AUTOSTOP_EN
        halt_d = halt_q;
        // Dropping run_en re-arms free-run.
        if (!run_en) halt_d = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                // Pending or fresh load wins over any generation request.
                if (load_req || pend_q) begin
                    state_d = S_LOAD;
                    idx_d   = 4'd0;
                    pend_d  = 1'b0;
                    if (load_req) pattern_d = load_pattern;
                end else if (step_req || (run_ok && period_q == '0)) begin
                    state_d = S_SCAN;
                    cnt_d   = '0;
                    snap_d  = alive;
                end
            end
            S_LOAD: begin
                if (idx_q == 4'd15) begin
                    state_d   = S_IDLE;
                    gen_d     = '0;
                    extinct_d = 1'b0;
                    stable_d  = 1'b0;
                    period_d  = '0;
`ifdef LIFE_CTRL_AUTOSTOP_EN
                    halt_d = 1'b0;
`endif
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_SCAN: begin
                if (cnt_q == SCAN_LAST) state_d = S_STEP;
                else                    cnt_d   = cnt_q + CNT_W'(1);
            end
            S_STEP: state_d = S_CHECK;
            S_CHECK: begin
                extinct_d = chk_ext;
                stable_d  = chk_stab;
                gen_d     = gen_q + GEN_W'(1);
                if (run_en) begin
                    state_d  = S_WAIT;
                    period_d = gen_period;
                end else begin
                    state_d = S_IDLE;
                end
`ifdef LIFE_CTRL_AUTOSTOP_EN
                if (run_en && (chk_ext || chk_stab)) begin
                    state_d = S_IDLE;
                    halt_d  = 1'b1;
                end
`endif
            end
            S_WAIT: begin
                if (period_q == '0) state_d  = S_IDLE;
                else                period_d = period_q - PERIOD_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // Loads arriving mid-generation are parked until the next IDLE.
        if (load_req && (state_q == S_SCAN || state_q == S_STEP ||
                         state_q == S_CHECK || state_q == S_WAIT)) begin
            pend_d    = 1'b1;
            pattern_d = load_pattern;
        end

        busy_d = (state_d != S_IDLE);
        we_d   = (state_d == S_LOAD);
        scan_d = (state_d == S_SCAN);
        run_d  = (state_d == S_STEP);
        if (state_d == S_LOAD) begin
            row_d = idx_d[3:2];
            col_d = idx_d[1:0];
            val_d = pattern_d[idx_d];
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 4'd0;
            pattern_q <= 16'h0000;
            snap_q    <= 16'h0000;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            gen_q     <= '0;
            extinct_q <= 1'b0;
            stable_q  <= 1'b0;
            busy_q    <= 1'b0;
            row_q     <= 2'd0;
            col_q     <= 2'd0;
            val_q     <= 1'b0;
            we_q      <= 1'b0;
            scan_q    <= 1'b0;
            run_q     <= 1'b0;
`ifdef LIFE_CTRL_AUTOSTOP_EN
            halt_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pattern_q <= pattern_d;
            snap_q    <= snap_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            gen_q     <= gen_d;
            extinct_q <= extinct_d;
            stable_q  <= stable_d;
            busy_q    <= busy_d;
            row_q     <= row_d;
            col_q     <= col_d;
            val_q     <= val_d;
            we_q      <= we_d;
            scan_q    <= scan_d;
            run_q     <= run_d;
`ifdef LIFE_CTRL_AUTOSTOP_EN
            halt_q    <= halt_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign gen_count = gen_q;
    assign extinct   = extinct_q;
    assign stable    = stable_q;
    assign row       = row_q;
    assign col       = col_q;
    assign val       = val_q;
    assign write_enb = we_q;
    assign scan      = scan_q;
    assign run       = run_q;

endmodule

// File: tb/tb_life_ctrl_4x4.sv
// Testbench for life_ctrl_4x4 with a behavioural 4x4 Life array attached.
`timescale 1ns/1ps
module tb_life_ctrl_4x4;
    localparam int unsigned SCAN_CYCLES = 16;
    localparam int unsigned PERIOD_W    = 16;
    localparam int unsigned GEN_W       = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                load_req, step_req, run_en;
    logic [15:0]         load_pattern;
    logic [PERIOD_W-1:0] gen_period;
    logic                busy;
    logic [GEN_W-1:0]    gen_count;
    logic                extinct, stable;
    logic [1:0]          row, col;
    logic                val, write_enb, scan, run;
    logic [15:0]         alive;
    logic [15:0]         cells = 16'h0000;

    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] exp_board;
    int          exp_gen;

    always #5 clk = ~clk;

    life_ctrl_4x4 #(
        .SCAN_CYCLES(SCAN_CYCLES), .PERIOD_W(PERIOD_W), .GEN_W(GEN_W)
    ) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .load_pattern(load_pattern),
        .step_req(step_req), .run_en(run_en), .gen_period(gen_period),
        .busy(busy), .gen_count(gen_count), .extinct(extinct), .stable(stable),
        .row(row), .col(col), .val(val), .write_enb(write_enb),
        .scan(scan), .run(run), .alive(alive)
    );

    // Conway rules on a bounded 4x4 board (cells off the edge are dead).
    function automatic logic [15:0] life_next(input logic [15:0] b);
        logic [15:0] nb;
        int n, rr, cc;
        nb = 16'h0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 4 && cc >= 0 && cc < 4)
                            n += int'(b[4*rr+cc]);
                    end
                end
                nb[4*r+c] = (n == 3) || (b[4*r+c] && n == 2);
            end
        end
        return nb;
    endfunction

    // Array model: cell writes and generation strobe.
    always @(posedge clk) begin
        if (write_enb)  cells[{row, col}] <= val;
        else if (run)   cells <= life_next(cells);
    end
    assign alive = cells;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({busy, gen_count, extinct, stable, row, col, val, write_enb, scan, run});
    endfunction

    task automatic do_load(input logic [15:0] pat);
        logic [3:0] ix;
        load_req = 1'b1;
        load_pattern = pat;
        @(negedge clk);
        load_req = 1'b0;
        load_pattern = ~pat;
        for (int i = 0; i < 16; i++) begin
            ix = 4'(i);
            check("load_write", 32'({busy, write_enb, row, col, val}),
                  32'({1'b1, 1'b1, ix[3:2], ix[1:0], pat[ix]}));
            @(negedge clk);
        end
        check("load_done", 32'({busy, write_enb, gen_count, extinct, stable}), 32'd0);
        check("load_alive", 32'(alive), 32'(pat));
        exp_board = pat;
        exp_gen = 0;
    endtask

    task automatic do_step();
        int scans, runs, n;
        logic ovl;
        logic [15:0] prev;
        prev = exp_board;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        scans = 0; runs = 0; n = 0; ovl = 1'b0;
        while (busy && n < 200) begin
            scans += int'(scan);
            runs  += int'(run);
            if (scan && run) ovl = 1'b1;
            @(negedge clk);
            n++;
        end
        exp_board = life_next(prev);
        exp_gen++;
        check("step_idle", 32'(busy), 32'd0);
        check("step_scan_len", 32'(scans), 32'(SCAN_CYCLES));
        check("step_runs", 32'(runs), 32'd1);
        check("step_overlap", 32'(ovl), 32'd0);
        check("step_alive", 32'(alive), 32'(exp_board));
        check("step_flags", 32'({extinct, stable}),
              32'({exp_board == 16'h0000, exp_board == prev}));
        check("step_gen", 32'(gen_count), 32'(exp_gen));
    endtask

    initial begin
        int runs, cyc, last, n, run_at, first_wr, writes;
        logic ovl;
        reset = 1'b1;
        load_req = 1'b0; step_req = 1'b0; run_en = 1'b0;
        load_pattern = 16'h0000; gen_period = '0;
        exp_board = 16'h0000; exp_gen = 0;
        repeat (2) @(negedge clk);
        check("reset_outs", all_outs(), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Async reset in the middle of a load.
        load_req = 1'b1; load_pattern = 16'hFFFF;
        @(negedge clk);
        load_req = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_load_idx5", 32'({write_enb, row, col}), 32'({1'b1, 4'd5}));
        #2 reset = 1'b1;
        #1 check("async_reset", all_outs(), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_idle", all_outs(), 32'd0);

        do_load(16'h0001);
        do_load(16'h0000);
        do_step();

        // Random seeds, single steps against the Life model.
        for (int k = 0; k < 6; k++) begin
            do_load(16'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int s = 0; s < 3; s++) do_step();
        end

        // Free-running blinker with gen_period=3.
        do_load(16'h0070);
        gen_period = PERIOD_W'(3);
        run_en = 1'b1;
        runs = 0; cyc = 0; last = 0; ovl = 1'b0;
        while (runs < 5 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (scan && run) ovl = 1'b1;
            if (run) begin
                runs++;
                if (runs > 1) begin
                    check("fr_spacing", 32'(cyc - last), 32'(SCAN_CYCLES + 3 + 4));
                    check("fr_flags", 32'({extinct, stable}), 32'd0);
                end
                check("fr_gen", 32'(gen_count), 32'(runs - 1));
                check("fr_alive", 32'(alive), 32'(exp_board));
                exp_board = life_next(exp_board);
                last = cyc;
            end
        end
        check("fr_runs", 32'(runs), 32'd5);
        run_en = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        exp_gen = runs;
        check("fr_stop_gen", 32'(gen_count), 32'(exp_gen));
        check("fr_stop_alive", 32'(alive), 32'(exp_board));
        check("fr_overlap", 32'(ovl), 32'd0);

        // Load request during SCAN: generation completes, then load.
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (3) @(negedge clk);
        load_req = 1'b1; load_pattern = 16'h8421; step_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0; step_req = 1'b0; load_pattern = 16'hDEAD;
        runs = 0; writes = 0; run_at = -1; first_wr = -1;
        for (int c = 0; c < 80; c++) begin
            if (run) begin runs++; run_at = c; end
            if (write_enb) begin
                writes++;
                if (first_wr < 0) first_wr = c;
            end
            @(negedge clk);
        end
        check("pend_runs", 32'(runs), 32'd1);
        check("pend_writes", 32'(writes), 32'd16);
        check("pend_order", 32'(first_wr > run_at), 32'd1);
        check("pend_state", 32'({busy, gen_count, extinct, stable}), 32'd0);
        check("pend_alive", 32'(alive), 32'h8421);
        exp_board = 16'h8421; exp_gen = 0;

        // Still-life block under free-run.
        do_load(16'h0033);
        gen_period = PERIOD_W'(2);
        run_en = 1'b1;
        runs = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (run) runs++;
        end
        run_en = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
`ifdef LIFE_CTRL_AUTOSTOP_EN
        check("block_runs_halted", 32'(runs), 32'd1);
`else
        check("block_runs_continue", 32'(runs > 1), 32'd1);
`endif
        check("block_flags", 32'({busy, extinct, stable}), 32'b001);
        check("block_gen", 32'(gen_count), 32'(runs));
        check("block_alive", 32'(alive), 32'h0033);
        exp_gen = runs;
        do_step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
